// File: rtl/datapath_bus.sv
// Accumulator-style datapath: nine architectural registers, a shared bus and a
// two-step ALU (capture into ALUR, then transfer to AC). Multiply: DATAPATH_MULT_EN.
module datapath_bus #(
  parameter logic [15:0] PC_RESET = 16'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] write_en,
  input  logic [15:0] inc_en,
  input  logic [15:0] clr_en,
  input  logic [3:0]  read_en,
  input  logic [2:0]  alu_op,
  output logic [15:0] im_addr,
  input  logic [15:0] im_rdata,
  output logic [15:0] dm_addr,
  input  logic [15:0] dm_rdata,
  output logic [15:0] dm_wdata,
  output logic        dm_we,
  output logic [15:0] z,
  output logic [5:0]  instruction
);

  logic [15:0] pc;
  logic [15:0] ar;
  logic [15:0] ir;
  logic [15:0] ac;
  logic [15:0] r;
  logic [15:0] r1;
  logic [15:0] r2;
  logic [15:0] r3;
  logic [15:0] r4;
  logic [15:0] alur;
  logic [15:0] bus;

  logic [15:0] alu_result;
  logic        alu_capture;
  logic        alu_transfer;

  always_comb begin
    case (read_en)
      4'd1:    bus = pc;
      4'd2:    bus = ar;
      4'd4:    bus = ir;
      4'd5:    bus = ac;
      4'd6:    bus = r;
      4'd7:    bus = r1;
      4'd8:    bus = r2;
      4'd9:    bus = r3;
      4'd10:   bus = r4;
      4'd12:   bus = dm_rdata;
      4'd13:   bus = im_rdata;
      default: bus = 16'd0;
    endcase
  end

  // alu_op 0 moves the held result into AC; nonzero codes compute from the current AC and R.
  always_comb begin
    alu_transfer = write_en[12] && (alu_op == 3'd0);
    alu_capture  = 1'b0;
    alu_result   = alur;
    if (write_en[12]) begin
      case (alu_op)
        3'd1: begin
          alu_capture = 1'b1;
          alu_result  = ac + r;
        end
        3'd2: begin
          alu_capture = 1'b1;
          alu_result  = ac - r;
        end
`ifdef DATAPATH_MULT_EN
        3'd3: begin
          alu_capture = 1'b1;
          alu_result  = ac * r;
        end
`endif
        3'd4: begin
          alu_capture = 1'b1;
          alu_result  = ac << 1;
        end
        default: begin
          alu_capture = 1'b0;
          alu_result  = alur;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= PC_RESET;
    end else if (clr_en[1]) begin
      pc <= PC_RESET;
    end else if (write_en[1]) begin
      pc <= bus;
    end else if (inc_en[1]) begin
      pc <= pc + 16'd1;
    end
  end

  // AC precedence: clear, then ALU transfer, then bus write, then increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac <= 16'd0;
    end else if (clr_en[4]) begin
      ac <= 16'd0;
    end else if (alu_transfer) begin
      ac <= alur;
    end else if (write_en[4]) begin
      ac <= bus;
    end else if (inc_en[4]) begin
      ac <= ac + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar <= 16'd0;
      ir <= 16'd0;
      r  <= 16'd0;
      r1 <= 16'd0;
      r2 <= 16'd0;
      r3 <= 16'd0;
      r4 <= 16'd0;
    end else begin
      if (write_en[2])  ar <= bus;
      if (write_en[3])  ir <= bus;
      if (write_en[5])  r  <= bus;
      if (write_en[7])  r4 <= bus;
      if (write_en[8])  r3 <= bus;
      if (write_en[9])  r2 <= bus;
      if (write_en[10]) r1 <= bus;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alur <= 16'd0;
    end else if (alu_capture) begin
      alur <= alu_result;
    end
  end

  assign im_addr     = pc;
  assign dm_addr     = ar;
  assign dm_wdata    = bus;
  assign dm_we       = write_en[11];
  assign z           = {15'd0, (ac == 16'd0)};
  assign instruction = ir[5:0];

  // Strobe bits with no register behind them.
  logic unused_strobes;
  assign unused_strobes = ^{write_en[0], write_en[6], write_en[15:13],
                            inc_en[0], inc_en[3:2], inc_en[15:5],
                            clr_en[0], clr_en[3:2], clr_en[15:5]};

endmodule

// File: doc/datapath_bus.md
DATAPATH_BUS -- requirements
Module: datapath_bus

Interface
REQ-001 The block SHALL have parameter PC_RESET, default 16'd0, defining the value PC takes on reset and on clr_en[1].
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active-low
- write_en  in  16  register write strobes
- inc_en  in  16  register increment strobes
- clr_en  in  16  register clear strobes
- read_en  in  4  bus-source select
- alu_op  in  3  ALU operation
- im_addr  out  16  instruction-memory address
- im_rdata  in  16  instruction-memory data
- dm_addr  out  16  data-memory address
- dm_rdata  in  16  data-memory data
- dm_wdata  out  16  data-memory write data
- dm_we  out  1  data-memory write strobe
- z  out  16  zero status
- instruction  out  6  opcode

Function
REQ-003 The block SHALL contain 16-bit registers PC, AR, IR, AC, R, R1, R2, R3, R4 and an ALU result register ALUR.
REQ-004 bus SHALL be combinational from read_en: 1 PC, 2 AR, 4 IR, 5 AC, 6 R, 7 R1, 8 R2, 9 R3, 10 R4, 12 dm_rdata, 13 im_rdata, any other code 16'd0.
REQ-005 write_en bit mapping SHALL be: 1 PC, 2 AR, 3 IR, 4 AC, 5 R, 7 R4, 8 R3, 9 R2, 10 R1; each selected register loads bus at the clock edge.
REQ-006 inc_en[1] SHALL add 1 to PC and inc_en[4] SHALL add 1 to AC, modulo 2^16 (16'hFFFF wraps to 16'h0000).
REQ-007 clr_en[1] SHALL load PC_RESET into PC and clr_en[4] SHALL load 16'd0 into AC.
REQ-008 When more than one strobe targets the same register in one cycle, priority SHALL be clear > ALU transfer > write > increment.
REQ-009 When write_en[12]=1 and alu_op is nonzero, ALUR SHALL capture: 1 AC+R, 2 AC-R, 3 low 16 bits of AC*R, 4 AC<<1; alu_op 5-7 SHALL leave ALUR unchanged.
REQ-010 When write_en[12]=1 and alu_op=0, AC SHALL load ALUR at the clock edge.
REQ-011 An ALU instruction SHALL therefore take two cycles: the result is visible on AC one cycle after the alu_op=0 cycle.
REQ-012 Captures in the same cycle SHALL use the old operand values.
REQ-013 im_addr SHALL equal PC and dm_addr SHALL equal AR.
REQ-014 Both memories are asynchronous-read; data read in a cycle SHALL be usable at that cycle's edge.
REQ-015 dm_we SHALL equal write_en[11] and dm_wdata SHALL equal bus, both combinationally.
REQ-016 instruction SHALL equal IR[5:0] and z SHALL equal {15'd0, (AC==16'd0)}, both combinationally.
REQ-017 write_en bits 0, 6, 13-15, inc_en and clr_en bits other than 1 and 4 SHALL be ignored.

Reset
REQ-018 rst_n low SHALL immediately set PC to PC_RESET and all other registers, including ALUR, to 16'd0, overriding any strobe.
REQ-019 After reset, z SHALL read 16'd1, instruction 6'd0 and dm_we 0.
REQ-020 Deasserting rst_n mid-instruction SHALL resume from reset values; no pending ALU result is retained.

Configuration
REQ-021 With macro DATAPATH_MULT_EN defined, alu_op 3 SHALL multiply as in REQ-009.
REQ-022 Without DATAPATH_MULT_EN, alu_op 3 SHALL leave ALUR unchanged and no multiplier SHALL be synthesised.

Verification
REQ-023 Load: read_en=13, im_rdata=16'h0003, write_en[3] for one cycle -> IR=16'h0003, instruction=6'd3.
REQ-024 Add: AC=5, R=7; write_en[12] with alu_op=1, then write_en[12] with alu_op=0 -> AC=12 after the second edge; z=0.
REQ-025 Wrap: AC=16'hFFFF, inc_en[4] -> AC=16'h0000, z=16'd1; the same cycle with clr_en[4] and write_en[4] asserted -> AC=0.
REQ-026 Store: AR=16'h0010, AC=16'h00AB, read_en=5, write_en[11] -> dm_we=1, dm_addr=16'h0010, dm_wdata=16'h00AB in that cycle only.
REQ-027 Mult: AC=16'h0100, R=16'h0100, alu_op=3 sequence -> AC=16'h0000 with DATAPATH_MULT_EN defined, and AC unchanged (prior ALUR) without it.
REQ-028 Reset: rst_n pulsed low between the two ALU cycles -> all registers cleared asynchronously, PC=PC_RESET, and the following alu_op=0 cycle loads AC=0.
